// File: rtl/cnn_pkg.sv
// Shared CNN datapath types, frame-size constants and index-width helper.
package cnn_pkg;

    typedef logic [15:0] fp16_t;

    localparam int CONV_OUT_W = 24;
    localparam int CONV_OUT_H = 24;

    // Width of a 0..n-1 index, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_window_feeder_if.sv
// Pixel-in / pooling-pair-out bundle between the conv stream, the feeder and the pooling stage.
interface pool_window_feeder_if #(
    parameter int IMG_W = cnn_pkg::CONV_OUT_W,
    parameter int IMG_H = cnn_pkg::CONV_OUT_H
);
    import cnn_pkg::*;

    localparam int ROW_W = idx_w(IMG_H / 2);
    localparam int COL_W = idx_w(IMG_W / 2);

    fp16_t             in_data;
    logic              in_valid;
    logic              in_ready;
    fp16_t             pool_a;
    fp16_t             pool_b;
    logic              pool_store;
    logic              pool_valid;
    logic [ROW_W-1:0]  pool_row;
    logic [COL_W-1:0]  pool_col;
    logic              pool_last;

    modport master (
        output in_data, in_valid,
        input  in_ready, pool_a, pool_b, pool_store, pool_valid, pool_row, pool_col, pool_last
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, pool_a, pool_b, pool_store, pool_valid, pool_row, pool_col, pool_last
    );

endinterface

// File: rtl/pool_line_buffer.sv
// One-row fp16 store: single write port, combinational read of an aligned pair (2c, 2c+1).
module pool_line_buffer
    import cnn_pkg::*;
#(
    parameter int IMG_W = CONV_OUT_W
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [idx_w(IMG_W)-1:0]    wr_addr,
    input  fp16_t                      wr_data,
    input  logic [idx_w(IMG_W/2)-1:0]  rd_pair,
    output fp16_t                      rd_lo,
    output fp16_t                      rd_hi
);

    fp16_t mem_q [IMG_W];

    // Contents are fully rewritten every even row, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_lo = mem_q[{rd_pair, 1'b0}];
    assign rd_hi = mem_q[{rd_pair, 1'b1}];

endmodule

// File: rtl/pool_window_feeder.sv
// Turns a row-major fp16 stream into top-pair/bottom-pair sequences for a 2x2 max-pool stage,
// with window valid/index/last flags delayed to line up with the pool stage's registered result.
module pool_window_feeder
    import cnn_pkg::*;
#(
    parameter int IMG_W = CONV_OUT_W,
    parameter int IMG_H = CONV_OUT_H
) (
    input  logic                 clk,
    input  logic                 rst,
    pool_window_feeder_if.slave  bus
);

    localparam int COLC_W = idx_w(IMG_W);
    localparam int ROWC_W = idx_w(IMG_H);
    localparam int PCOL_W = idx_w(IMG_W / 2);
    localparam int PROW_W = idx_w(IMG_H / 2);
    localparam logic [COLC_W-1:0] COL_LAST = COLC_W'(IMG_W - 1);
    localparam logic [ROWC_W-1:0] ROW_LAST = ROWC_W'(IMG_H - 1);

    logic              in_ready;
    logic              accept;
    logic              lb_we;
    logic [PCOL_W-1:0] pair_idx;
    fp16_t             lb_lo, lb_hi;

    logic [COLC_W-1:0] col_q, col_d;
    logic [ROWC_W-1:0] row_q, row_d;
    fp16_t             hold_px_q, hold_px_d;
    fp16_t             pool_a_q, pool_a_d;
    fp16_t             pool_b_q, pool_b_d;
    logic              pool_store_q, pool_store_d;

    logic              vld_p0_q, vld_p0_d, last_p0_q, last_p0_d;
    logic [PROW_W-1:0] row_p0_q, row_p0_d;
    logic [PCOL_W-1:0] col_p0_q, col_p0_d;
    logic              vld_p1_q, vld_p1_d, last_p1_q, last_p1_d;
    logic [PROW_W-1:0] row_p1_q, row_p1_d;
    logic [PCOL_W-1:0] col_p1_q, col_p1_d;
    logic              pool_valid_q, pool_valid_d, pool_last_q, pool_last_d;
    logic [PROW_W-1:0] pool_row_q, pool_row_d;
    logic [PCOL_W-1:0] pool_col_q, pool_col_d;

    assign in_ready = ~rst;
    assign accept   = bus.in_valid && in_ready;
    assign lb_we    = accept && !row_q[0];
    assign pair_idx = PCOL_W'(col_q >> 1);

    pool_line_buffer #(.IMG_W(IMG_W)) u_line_buf (
        .clk     (clk),
        .wr_en   (lb_we),
        .wr_addr (col_q),
        .wr_data (bus.in_data),
        .rd_pair (pair_idx),
        .rd_lo   (lb_lo),
        .rd_hi   (lb_hi)
    );

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        hold_px_d    = hold_px_q;
        pool_a_d     = pool_a_q;
        pool_b_d     = pool_b_q;
        pool_store_d = 1'b0;
        vld_p0_d     = 1'b0;
        last_p0_d    = 1'b0;
        row_p0_d     = row_p0_q;
        col_p0_d     = col_p0_q;

        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            if (row_q[0]) begin
                if (!col_q[0]) begin
                    // Park the bottom-left pixel until its right neighbour arrives.
                    hold_px_d    = bus.in_data;
                    pool_a_d     = lb_lo;
                    pool_b_d     = lb_hi;
                    pool_store_d = 1'b1;
                end else begin
                    pool_a_d  = hold_px_q;
                    pool_b_d  = bus.in_data;
                    vld_p0_d  = 1'b1;
                    last_p0_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
                    row_p0_d  = PROW_W'(row_q >> 1);
                    col_p0_d  = pair_idx;
                end
            end
        end

        vld_p1_d     = vld_p0_q;
        last_p1_d    = last_p0_q;
        row_p1_d     = row_p0_q;
        col_p1_d     = col_p0_q;
        pool_valid_d = vld_p1_q;
        pool_last_d  = last_p1_q;
        pool_row_d   = row_p1_q;
        pool_col_d   = col_p1_q;
    end

    // Stage p0: counters, pair outputs and window tag capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            pool_a_q     <= '0;
            pool_b_q     <= '0;
            pool_store_q <= 1'b0;
            vld_p0_q     <= 1'b0;
            last_p0_q    <= 1'b0;
            row_p0_q     <= '0;
            col_p0_q     <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            pool_a_q     <= pool_a_d;
            pool_b_q     <= pool_b_d;
            pool_store_q <= pool_store_d;
            vld_p0_q     <= vld_p0_d;
            last_p0_q    <= last_p0_d;
            row_p0_q     <= row_p0_d;
            col_p0_q     <= col_p0_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_px_q <= hold_px_d;
    end

    // Stages p1 and output: tag delay matching the pooling stage latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q     <= 1'b0;
            last_p1_q    <= 1'b0;
            row_p1_q     <= '0;
            col_p1_q     <= '0;
            pool_valid_q <= 1'b0;
            pool_last_q  <= 1'b0;
            pool_row_q   <= '0;
            pool_col_q   <= '0;
        end else begin
            vld_p1_q     <= vld_p1_d;
            last_p1_q    <= last_p1_d;
            row_p1_q     <= row_p1_d;
            col_p1_q     <= col_p1_d;
            pool_valid_q <= pool_valid_d;
            pool_last_q  <= pool_last_d;
            pool_row_q   <= pool_row_d;
            pool_col_q   <= pool_col_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.pool_a     = pool_a_q;
    assign bus.pool_b     = pool_b_q;
    assign bus.pool_store = pool_store_q;
    assign bus.pool_valid = pool_valid_q;
    assign bus.pool_row   = pool_row_q;
    assign bus.pool_col   = pool_col_q;
    assign bus.pool_last  = pool_last_q;

endmodule

// File: tb/tb_pool_window_feeder.sv
// Scoreboard bench: the driver builds each frame in a 2D array and queues every completed 2x2 window.
module tb_pool_window_feeder;
    import cnn_pkg::*;

    localparam int W = 4;
    localparam int H = 4;

    typedef struct {
        int r; int c; int last;
        int ta; int tb; int ba; int bb;
        int acc;
    } win_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    win_t        exp_q[$];
    logic [15:0] stim [H][W];
    logic [15:0] cur  [H][W];
    int          prow, pcol;
    logic [15:0] specials [4] = '{16'h7E00, 16'h7C00, 16'hFC00, 16'h8000};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pool_window_feeder_if #(.IMG_W(W), .IMG_H(H)) bus ();

    pool_window_feeder #(.IMG_W(W), .IMG_H(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Driver: one pixel per call; reference model records it and queues finished windows.
    task automatic send_px(input logic [15:0] px);
        win_t e;
        bus.in_valid = 1'b1;
        bus.in_data  = px;
        @(posedge clk);
        cur[prow][pcol] = px;
        if ((prow % 2 == 1) && (pcol % 2 == 1)) begin
            e.r    = prow / 2;
            e.c    = pcol / 2;
            e.last = (prow == H - 1 && pcol == W - 1) ? 1 : 0;
            e.ta   = int'(cur[prow-1][pcol-1]);
            e.tb   = int'(cur[prow-1][pcol]);
            e.ba   = int'(cur[prow][pcol-1]);
            e.bb   = int'(px);
            e.acc  = cyc;
            exp_q.push_back(e);
        end
        if (pcol == W - 1) begin
            pcol = 0;
            prow = (prow == H - 1) ? 0 : prow + 1;
        end else begin
            pcol = pcol + 1;
        end
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int gap_at, input int gap_len, input bit rand_gaps);
        logic [31:0] x;
        for (int i = 0; i < W * H; i++) begin
            if (i == gap_at) idle(gap_len);
            if (rand_gaps) begin
                x = $urandom();
                if (x[1:0] == 2'b00) idle(int'(x[3:2]) + 1);
            end
            send_px(stim[i / W][i % W]);
        end
    endtask

    task automatic load_frame_a();
        stim[0] = '{16'h3C00, 16'h4000, 16'h0000, 16'h0000};
        stim[1] = '{16'h4200, 16'h4400, 16'h0000, 16'h0000};
        stim[2] = '{16'h0000, 16'h0000, 16'hBC00, 16'hC000};
        stim[3] = '{16'h0000, 16'h0000, 16'hC200, 16'h3800};
    endtask

    task automatic load_frame_top();
        stim[0] = '{16'h4800, 16'h3C00, 16'h8000, 16'h7C00};
        stim[1] = '{16'h3C00, 16'h3C00, 16'hFC00, 16'h7E00};
        stim[2] = '{16'h0001, 16'hFFFF, 16'h7BFF, 16'h0400};
        stim[3] = '{16'h8001, 16'h0000, 16'hFBFF, 16'h3555};
    endtask

    task automatic load_frame_rand();
        logic [31:0] x;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                x = $urandom();
                stim[r][c] = (x[31:29] == 3'b000) ? specials[x[1:0]] : x[15:0];
            end
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_pool_a",     int'(bus.pool_a),     0);
        chk("rst_pool_b",     int'(bus.pool_b),     0);
        chk("rst_pool_store", int'(bus.pool_store), 0);
        chk("rst_pool_valid", int'(bus.pool_valid), 0);
        chk("rst_pool_last",  int'(bus.pool_last),  0);
        chk("rst_pool_row",   int'(bus.pool_row),   0);
        chk("rst_pool_col",   int'(bus.pool_col),   0);
        chk("rst_in_ready",   int'(bus.in_ready),   0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        chk("drain_pending", exp_q.size(), 0);
        #1;
    endtask

    // Monitor: keeps two cycles of pair history so the bottom pair of a window can be
    // matched against the cycle its pool_valid appears in.
    logic [15:0] ha [3], hb [3], hta [3], htb [3];
    int          hcnt [3];
    logic [15:0] top_a, top_b;
    int          store_cnt = 0;
    int          cnt_used  = 0;

    always @(negedge clk) begin
        win_t e;
        if (rst) begin
            store_cnt = 0;
            cnt_used  = 0;
        end else begin
            chk("in_ready", int'(bus.in_ready), 1);
            if (bus.pool_store) begin
                top_a = bus.pool_a;
                top_b = bus.pool_b;
                store_cnt++;
            end
            for (int i = 2; i > 0; i--) begin
                ha[i] = ha[i-1]; hb[i] = hb[i-1];
                hta[i] = hta[i-1]; htb[i] = htb[i-1]; hcnt[i] = hcnt[i-1];
            end
            ha[0] = bus.pool_a; hb[0] = bus.pool_b;
            hta[0] = top_a; htb[0] = top_b; hcnt[0] = store_cnt;

            if (bus.pool_last && !bus.pool_valid) begin
                chk("last_without_valid", 1, 0);
            end
            if (bus.pool_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency",   cyc,                 e.acc + 3);
                    chk("pool_row",  int'(bus.pool_row),  e.r);
                    chk("pool_col",  int'(bus.pool_col),  e.c);
                    chk("pool_last", int'(bus.pool_last), e.last);
                    chk("top_a",     int'(hta[2]),        e.ta);
                    chk("top_b",     int'(htb[2]),        e.tb);
                    chk("bot_a",     int'(ha[2]),         e.ba);
                    chk("bot_b",     int'(hb[2]),         e.bb);
                    chk("store_pulses", hcnt[2] - cnt_used, 1);
                    cnt_used = hcnt[2];
                end
            end
        end
    end

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        prow = 0;
        pcol = 0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        @(posedge clk);
        #1 rst = 1'b0;

        load_frame_a();
        run_frame(-1, 0, 1'b0);
        drain();

        load_frame_a();
        run_frame(5, 3, 1'b0);
        drain();

        load_frame_top();
        run_frame(-1, 0, 1'b0);
        drain();

        load_frame_a();
        for (int i = 0; i < 6; i++) send_px(stim[i / W][i % W]);
        rst = 1'b1;
        exp_q.delete();
        prow = 0;
        pcol = 0;
        repeat (2) @(negedge clk);
        check_reset_vals();
        @(posedge clk);
        #1 rst = 1'b0;
        load_frame_a();
        run_frame(-1, 0, 1'b0);
        drain();

        load_frame_a();
        run_frame(-1, 0, 1'b0);
        load_frame_top();
        run_frame(-1, 0, 1'b0);
        drain();

        for (int f = 0; f < 40; f++) begin
            load_frame_rand();
            run_frame(-1, 0, (f % 2) == 1);
        end
        drain();
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
